// File: rtl/l2_types_pkg.sv
// Shared types for the L2 control path: FSM state encoding and datapath write modes.
// No logic lives here, so there is no latency or backpressure to describe.
// Imported by l2_repl and l2_control_nway.
package l2_types_pkg;

    typedef enum logic [1:0] {
        ST_ACCESS     = 2'd0,
        ST_WRITE_BACK = 2'd1,
        ST_ALLOCATE   = 2'd2
    } l2_state_t;

    localparam logic [1:0] DM_NONE = 2'b00;
    localparam logic [1:0] DM_BYTE = 2'b01;
    localparam logic [1:0] DM_LINE = 2'b10;

endpackage

// File: rtl/l2_repl.sv
// Per-set replacement state: tree pseudo-LRU with L2_PLRU_EN, round-robin otherwise.
// The victim is combinational from the addressed set; touch/fill take effect on the next edge.
// No backpressure: touch and fill are single-cycle strobes from the control FSM.
module l2_repl
    import l2_types_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] index,
    input  logic             touch,
    input  logic [WAY_W-1:0] touch_way,
    input  logic             fill,
    output logic [WAY_W-1:0] victim
);

`ifdef L2_PLRU_EN
    logic [WAYS-2:0] plru_q [SETS];
    logic [WAYS-2:0] plru_d;
    logic            unused_fill;

    assign unused_fill = fill;

    // Walk up from the touched leaf, pointing each ancestor at the other half.
    function automatic logic [WAYS-2:0] plru_touch(logic [WAYS-2:0] bits, logic [WAY_W-1:0] w);
        int n;
        int p;
        n = int'(w) + WAYS - 1;
        for (int l = 0; l < WAY_W; l++) begin
            p       = (n - 1) / 2;
            bits[p] = (n == 2 * p + 1);
            n       = p;
        end
        return bits;
    endfunction

    always_comb begin
        logic [WAYS-2:0] cur;
        int              node;
        cur  = plru_q[index];
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            node = 2 * node + 1 + int'(cur[node]);
        end
        victim = WAY_W'(node - (WAYS - 1));
        plru_d = plru_touch(cur, touch_way);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else if (touch) begin
            plru_q[index] <= plru_d;
        end
    end
`else
    logic [WAY_W-1:0] rr_q [SETS];
    logic             unused_touch;

    assign unused_touch = touch ^ (^touch_way);
    assign victim       = rr_q[index];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
        end else if (fill) begin
            rr_q[index] <= rr_q[index] + WAY_W'(1);
        end
    end
`endif

endmodule

// File: rtl/l2_control_nway.sv
// Control FSM for the N-way write-back L2 (replacement policy selected by L2_PLRU_EN).
// Hits complete combinationally in the request cycle; misses stall in WRITE_BACK/ALLOCATE.
// Physical-memory strobes hold until pmem_resp; the CPU holds its request until mem_resp.
module l2_control_nway
    import l2_types_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int SETS  = 8,
    parameter int IDX_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             read_array,
    input  logic             write_array,
    input  logic [IDX_W-1:0] index,
    input  logic [WAYS-1:0]  hit,
    input  logic [WAYS-1:0]  valid,
    input  logic [WAYS-1:0]  dirty,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             pmem_select,
    output logic             data_select,
    output logic             dirty_select,
    output logic [1:0]       data_mode,
    output logic [WAYS-1:0]  way_load,
    output logic [WAY_W-1:0] way_sel
);

    l2_state_t        state_q, state_d;
    logic [WAY_W-1:0] victim_q, victim_d;
    logic [IDX_W-1:0] index_q, index_d;

    logic [WAYS-1:0]  eh;
    logic             hit_any, inv_any;
    logic [WAY_W-1:0] hit_way, inv_way, repl_victim, miss_victim;
    logic [IDX_W-1:0] repl_index;
    logic             touch, fill;

    assign eh      = hit & valid;
    assign hit_any = |eh;
    assign inv_any = ~&valid;

    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (eh[w])     hit_way = WAY_W'(w);
            if (!valid[w]) inv_way = WAY_W'(w);
        end
    end

    assign miss_victim = inv_any ? inv_way : repl_victim;
    // The fill targets the latched set, not whatever index the CPU shows now.
    assign repl_index  = (state_q == ST_ALLOCATE) ? index_q : index;

    l2_repl #(.WAYS(WAYS), .SETS(SETS), .IDX_W(IDX_W), .WAY_W(WAY_W)) u_repl (
        .clk       (clk),
        .rst_n     (rst_n),
        .index     (repl_index),
        .touch     (touch),
        .touch_way (hit_way),
        .fill      (fill),
        .victim    (repl_victim)
    );

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        index_d      = index_q;
        touch        = 1'b0;
        fill         = 1'b0;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_select  = 1'b0;
        data_select  = 1'b1;
        dirty_select = 1'b0;
        data_mode    = DM_NONE;
        way_load     = '0;
        way_sel      = '0;
        case (state_q)
            ST_ACCESS: begin
                if (read_array || write_array) begin
                    if (hit_any) begin
                        mem_resp = 1'b1;
                        way_sel  = hit_way;
                        touch    = 1'b1;
                        if (write_array) begin
                            way_load     = WAYS'(1) << hit_way;
                            data_mode    = DM_BYTE;
                            data_select  = 1'b0;
                            dirty_select = 1'b1;
                        end
                    end else begin
                        victim_d = miss_victim;
                        index_d  = index;
                        state_d  = (valid[miss_victim] && dirty[miss_victim])
                                   ? ST_WRITE_BACK : ST_ALLOCATE;
                    end
                end
            end
            ST_WRITE_BACK: begin
                pmem_write  = 1'b1;
                pmem_select = 1'b1;
                way_sel     = victim_q;
                if (pmem_resp) state_d = ST_ALLOCATE;
            end
            ST_ALLOCATE: begin
                pmem_read = 1'b1;
                way_sel   = victim_q;
                if (pmem_resp) begin
                    way_load  = WAYS'(1) << victim_q;
                    data_mode = DM_LINE;
                    fill      = 1'b1;
                    state_d   = ST_ACCESS;
                end
            end
            default: state_d = ST_ACCESS;
        endcase
        if (!rst_n) begin
            touch        = 1'b0;
            fill         = 1'b0;
            mem_resp     = 1'b0;
            pmem_read    = 1'b0;
            pmem_write   = 1'b0;
            pmem_select  = 1'b0;
            data_select  = 1'b1;
            dirty_select = 1'b0;
            data_mode    = DM_NONE;
            way_load     = '0;
            way_sel      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_ACCESS;
            victim_q <= '0;
            index_q  <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            index_q  <= index_d;
        end
    end

endmodule

// File: tb/tb_l2_control_nway.sv
// Randomized bench for l2_control_nway: a cache-environment model supplies hit/valid/dirty
// and predicts every handshake from the replacement rules (L2_PLRU_EN selects the policy).
module tb_l2_control_nway;
    localparam int WAYS = 4;
    localparam int SETS = 8;

    logic       clk = 1'b0;
    logic       rst_n, read_array, write_array, pmem_resp;
    logic [2:0] index;
    logic [3:0] hit, valid, dirty;
    logic       mem_resp, pmem_read, pmem_write, pmem_select, data_select, dirty_select;
    logic [1:0] data_mode;
    logic [3:0] way_load;
    logic [1:0] way_sel;

    int n_vec = 0;
    int n_err = 0;

    // Environment: the tag/valid/dirty arrays the cache top would hold.
    int              tag_m [SETS][WAYS];
    logic [WAYS-1:0] val_m [SETS];
    logic [WAYS-1:0] dty_m [SETS];
    logic [WAYS-2:0] plru_m [SETS];
    int              rr_m  [SETS];

    l2_control_nway #(.WAYS(WAYS), .SETS(SETS)) dut (
        .clk(clk), .rst_n(rst_n), .read_array(read_array), .write_array(write_array),
        .index(index), .hit(hit), .valid(valid), .dirty(dirty), .pmem_resp(pmem_resp),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_select(pmem_select), .data_select(data_select), .dirty_select(dirty_select),
        .data_mode(data_mode), .way_load(way_load), .way_sel(way_sel)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic repl_reset();
        for (int s = 0; s < SETS; s++) begin
            plru_m[s] = '0;
            rr_m[s]   = 0;
        end
    endtask

    // Tree PLRU viewed as nested halves of the way range.
    function automatic int m_victim(input int s);
`ifdef L2_PLRU_EN
        int lo = 0, hi = WAYS, node = 0, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (plru_m[s][node] == 1'b0) begin hi = mid; node = 2 * node + 1; end
            else begin lo = mid; node = 2 * node + 2; end
        end
        return lo;
`else
        return rr_m[s];
`endif
    endfunction

    task automatic m_touch(input int s, input int w);
`ifdef L2_PLRU_EN
        int lo = 0, hi = WAYS, node = 0, mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (w < mid) begin plru_m[s][node] = 1'b1; hi = mid; node = 2 * node + 1; end
            else begin plru_m[s][node] = 1'b0; lo = mid; node = 2 * node + 2; end
        end
`else
        if (w < 0) rr_m[s] = 0;
`endif
    endtask

    task automatic drive_env(input int s, input int tag);
        index = 3'(s);
        for (int w = 0; w < WAYS; w++) hit[w] = (tag_m[s][w] == tag);
        valid = val_m[s];
        dirty = dty_m[s];
    endtask

    task automatic scramble();
        hit         = 4'($urandom);
        valid       = 4'($urandom);
        dirty       = 4'($urandom);
        index       = 3'($urandom);
        read_array  = 1'($urandom);
        write_array = 1'($urandom);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_mem_resp"}, mem_resp, 0);
        check_eq({tag, "_pmem"}, {pmem_read, pmem_write, pmem_select}, 0);
        check_eq({tag, "_dsel"}, data_select, 1);
        check_eq({tag, "_load"}, {way_load, data_mode, dirty_select}, 0);
    endtask

    // Inputs for a hitting request are already applied; check and update the model.
    task automatic check_hit(input int s, input bit wr);
        logic [3:0] eh;
        int hw;
        eh = hit & valid;
        hw = 0;
        for (int w = WAYS - 1; w >= 0; w--) if (eh[w]) hw = w;
        check_eq("hit_mem_resp", mem_resp, 1);
        check_eq("hit_way_sel", way_sel, hw);
        check_eq("hit_pmem", {pmem_read, pmem_write}, 0);
        if (wr) begin
            check_eq("wr_way_load", way_load, 4'b0001 << hw);
            check_eq("wr_mode", {data_mode, data_select, dirty_select}, {2'b01, 1'b0, 1'b1});
            dty_m[s][hw] = 1'b1;
        end else begin
            check_eq("rd_way_load", way_load, 0);
            check_eq("rd_mode", data_mode, 0);
        end
        m_touch(s, hw);
    endtask

    task automatic do_req(input int s, input int tag, input bit wr, input bit rd_too,
                          input int wbl, input int all);
        int v;
        step();
        read_array  = wr ? rd_too : 1'b1;
        write_array = wr;
        pmem_resp   = 1'b0;
        drive_env(s, tag);
        #2;
        if ((hit & valid) != 0) begin
            check_hit(s, wr);
            return;
        end
        v = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!val_m[s][w]) v = w;
        if (v < 0) v = m_victim(s);
        check_eq("miss_mem_resp", mem_resp, 0);
        check_eq("miss_pmem", {pmem_read, pmem_write}, 0);
        if (val_m[s][v] && dty_m[s][v]) begin
            for (int c = 0; c <= wbl; c++) begin
                step();
                scramble();
                pmem_resp = (c == wbl);
                #2;
                check_eq("wb_strobes", {pmem_write, pmem_select, pmem_read}, 3'b110);
                check_eq("wb_way_sel", way_sel, v);
                check_eq("wb_no_resp", {mem_resp, way_load}, 0);
            end
        end
        for (int c = 0; c <= all; c++) begin
            step();
            scramble();
            pmem_resp = (c == all);
            #2;
            check_eq("al_strobes", {pmem_read, pmem_write, pmem_select}, 3'b100);
            check_eq("al_way_sel", way_sel, v);
            check_eq("al_way_load", way_load, (c == all) ? (4'b0001 << v) : 4'b0000);
            check_eq("al_mode", {data_mode, data_select},
                     (c == all) ? {2'b10, 1'b1} : {2'b00, 1'b1});
            check_eq("al_no_resp", mem_resp, 0);
        end
        tag_m[s][v] = tag;
        val_m[s][v] = 1'b1;
        dty_m[s][v] = 1'b0;
        rr_m[s]     = (rr_m[s] + 1) % WAYS;
        step();
        pmem_resp   = 1'b0;
        read_array  = wr ? rd_too : 1'b1;
        write_array = wr;
        drive_env(s, tag);
        #2;
        check_eq("refill_pmem_drop", {pmem_read, pmem_write}, 0);
        check_hit(s, wr);
    endtask

    initial begin
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) tag_m[s][w] = -1;
            val_m[s] = '0;
            dty_m[s] = '0;
        end
        repl_reset();
        rst_n = 1'b0; read_array = 1'b1; write_array = 1'b1; pmem_resp = 1'b1;
        index = 3'd3; hit = 4'hF; valid = 4'hF; dirty = 4'hF;
        step();
        #2 check_idle("reset");
        step();
        rst_n = 1'b1; read_array = 1'b0; write_array = 1'b0; pmem_resp = 1'b0;
        #2 check_idle("access_idle");

        // Set 3: fill every way, then shape PLRU so way 2 (dirty) is the victim.
        for (int w = 0; w < WAYS; w++) do_req(3, 10 + w, 1'b0, 1'b0, 0, $urandom_range(0, 3));
        do_req(3, 12, 1'b1, 1'b0, 0, 0);
        do_req(3, 13, 1'b0, 1'b0, 0, 0);
        do_req(3, 10, 1'b0, 1'b0, 0, 0);
        do_req(3, 11, 1'b1, 1'b1, 0, 0);
        do_req(3, 20, 1'b0, 1'b0, 3, 2);

        // Lowest effective hit wins.
        step();
        read_array = 1'b1; write_array = 1'b0; index = 3'd3;
        hit = 4'b0110; valid = 4'hF; dirty = dty_m[3];
        #2 check_hit(3, 1'b0);

        // valid=1011 with a stale matching tag in the invalid way.
        tag_m[5][0] = 30; tag_m[5][1] = 31; tag_m[5][2] = 40; tag_m[5][3] = 33;
        val_m[5] = 4'b1011; dty_m[5] = 4'b1111;
        do_req(5, 40, 1'b0, 1'b0, 0, 5);

        // Reset while ALLOCATE is waiting: the fill is abandoned.
        step();
        read_array = 1'b1; write_array = 1'b0; pmem_resp = 1'b0; drive_env(6, 7);
        #2 check_eq("pre_rst_miss", mem_resp, 0);
        for (int c = 0; c < 2; c++) begin
            step();
            #2 check_eq("pre_rst_pmem_read", pmem_read, 1);
        end
        step();
        rst_n = 1'b0;
        #2 check_eq("rst_pmem_read", pmem_read, 0);
        step();
        rst_n = 1'b1; read_array = 1'b0; pmem_resp = 1'b1;
        #2 check_idle("post_rst");
        repl_reset();
        pmem_resp = 1'b0;
        for (int k = 0; k < 3; k++) do_req(3, 50 + k, 1'b0, 1'b0, 1, 1);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                step();
                read_array = 1'b0; write_array = 1'b0; pmem_resp = 1'($urandom);
                hit = 4'($urandom); valid = 4'($urandom); dirty = 4'($urandom);
                #2 check_idle("rand_idle");
            end
            do_req($urandom_range(0, SETS - 1), $urandom_range(0, 5), 1'($urandom),
                   1'($urandom), $urandom_range(0, 3), $urandom_range(0, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/l2_control_nway.md
# l2_control_nway

Control FSM for the N-way, set-associative, write-back L2 cache. It sits between the cache top level, which supplies request strobes and per-way hit/valid/dirty status, and the datapath. It drives the way-indexed load enables, the datapath muxes and the physical-memory handshake. Per-set replacement state is held internally and replacement is by tree pseudo-LRU. The victim is latched at miss detection, invalid ways are filled before valid ones, and physical-memory loads are gated on `pmem_resp`.

## Interface
Parameters:
- `WAYS`, 4: associativity. Power of two, ≥2.
- `SETS`, 8: number of sets. Power of two.
- `IDX_W`, `$clog2(SETS)`: set index width.
- `WAY_W`, `$clog2(WAYS)`: way number width.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `read_array` / `write_array`  in  1  CPU-side read / write request; held until `mem_resp`.
- `index`  in  IDX_W  set index of the current request.
- `hit`  in  WAYS  per-way tag-match.
- `valid` / `dirty`  in  WAYS  per-way valid / dirty bits of the indexed set.
- `pmem_resp`  in  1  physical-memory completion.
- `mem_resp`  out  1  request complete.
- `pmem_read` / `pmem_write`  out  1  physical-memory strobes.
- `pmem_select`  out  1  1 = write-back address (victim tag + index); 0 = request address.
- `data_select`  out  1  1 = line data from `pmem_rdata`; 0 = `mem_wdata`.
- `dirty_select`  out  1  value written into the dirty array.
- `data_mode`  out  2  00 no write, 01 byte-enable write, 10 full-line write.
- `way_load`  out  WAYS  one-hot load for the tag/valid/dirty/data arrays of one way.
- `way_sel`  out  WAY_W  way driving the tag and data-out muxes.

## Operation
- Effective hit vector `eh = hit & valid`. If more than one bit is set, the lowest index wins.
- Request priority: if both strobes are high, `write_array` takes priority.
- States: ACCESS, WRITE_BACK, ALLOCATE.
- ACCESS, read hit:
  - `mem_resp=1`.
  - `way_sel` = hit way.
  - PLRU of `index` updated toward the hit way.
- ACCESS, write hit, same as a read hit plus:
  - `way_load` = onehot(hit way).
  - `data_mode=01`, `data_select=0`, `dirty_select=1`.
- ACCESS, miss (request with `eh==0`):
  - Victim = lowest-index way with `valid==0`; if every way is valid, the PLRU victim.
  - Victim latched into `victim_q`; index latched into `index_q`.
  - Victim dirty and valid → WRITE_BACK; otherwise → ALLOCATE.
  - No `mem_resp`.
- WRITE_BACK:
  - `pmem_write=1`, `pmem_select=1`, `way_sel=victim_q`.
  - On `pmem_resp` → ALLOCATE.
- ALLOCATE:
  - `pmem_read=1`, `way_sel=victim_q`.
  - In the `pmem_resp` cycle only: `way_load=onehot(victim_q)`, `data_mode=10`, `data_select=1`, `dirty_select=0`. Then → ACCESS.
  - The request then hits on re-entry to ACCESS.
- A request dropped mid-miss still completes the fill; no `mem_resp` is issued unless a request is present in ACCESS.
- PLRU (per set, WAYS-1 bits, heap-ordered):
  - Bit 0 = victim in the left subtree.
  - Access to way w sets every node on w's path to point away from w.
- PLRU state updates only on hit cycles. Fills do not update it; the following hit does.

## Timing
- Hit: `mem_resp` is combinational in the same cycle as the request. Latency 0.
- Clean miss: 1 ACCESS cycle + ALLOCATE until `pmem_resp` + 1 ACCESS hit cycle.
- Dirty miss: adds WRITE_BACK until `pmem_resp`.
- `pmem_read` and `pmem_write` stay high until the cycle of `pmem_resp`, inclusive, and drop the next cycle.
- Reset (`rst_n=0` at a clock edge, including mid-miss):
  - state → ACCESS; all PLRU bits and counters → 0; `victim_q`, `index_q` → 0.
  - Every output is 0 while in reset, except `data_select=1`.
  - An outstanding pmem transaction is abandoned.
- Outputs in ACCESS with no request: all 0 except `data_select=1`.

## Configuration
- `L2_PLRU_EN` defined: tree pseudo-LRU as above.
- `L2_PLRU_EN` undefined:
  - Per-set WAY_W-bit round-robin pointer.
  - Victim = pointer; the pointer increments, wrapping modulo WAYS, in the ALLOCATE `pmem_resp` cycle.
  - Hits do not change it.
- In both modes, the invalid-way-first rule overrides the replacement policy.

## Structure
- Package `l2_types_pkg`:
  - State enum `l2_state_t`.
  - `data_mode` encodings as localparams `DM_NONE`, `DM_BYTE`, `DM_LINE`.
- Sub-module `l2_repl`:
  - Per-set replacement storage plus victim logic; the `L2_PLRU_EN` switch lives here.
  - Ports: `clk`, `rst_n`, `index`, `touch`, `touch_way`, `fill`, `victim`.

## Test plan
- Reset, then WAYS=4, set 3 all valid, read hitting way 0 → `mem_resp` same cycle; next PLRU victim of set 3 = way 2.
- Write hit way 1 → `way_load=4'b0010`, `data_mode=01`, `dirty_select=1`, `mem_resp=1`.
- Read miss, `valid=4'b1011` → victim way 2, straight to ALLOCATE. `pmem_resp` after 5 cycles → `way_load=4'b0100` for exactly 1 cycle, then hit.
- Read miss, all valid, PLRU victim 2 dirty → WRITE_BACK with `pmem_select=1`, `way_sel=2`; `pmem_resp` → ALLOCATE → ACCESS. `way_sel` stays 2 even if `dirty`/`valid` inputs change mid-miss.
- `rst_n` low during ALLOCATE → `pmem_read=0` the next cycle, state ACCESS, PLRU cleared (victim way 0).
- Without `L2_PLRU_EN`: three successive full-set misses in one set → victims 0, 1, 2.
